// File: rtl/assoc_wb_cache_ctrl_if.sv
// CPU load/store port, flush control and memory port
// of the set-associative write-back cache controller.
interface assoc_wb_cache_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                cpu_req_valid;
  logic                cpu_req_ready;
  logic                cpu_req_we;
  logic [ADDR_W-1:0]   cpu_req_addr;
  logic [DATA_W-1:0]   cpu_req_wdata;
  logic [DATA_W/8-1:0] cpu_req_be;
  logic                cpu_resp_valid;
  logic [DATA_W-1:0]   cpu_resp_rdata;
  logic                flush_req;
  logic                flush_done;
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic                mem_req_we;
  logic [ADDR_W-1:0]   mem_req_addr;
  logic [DATA_W-1:0]   mem_req_wdata;
  logic                mem_resp_valid;
  logic [DATA_W-1:0]   mem_resp_rdata;

  modport master (
    output cpu_req_valid, cpu_req_we,
    output cpu_req_addr, cpu_req_wdata,
    output cpu_req_be, flush_req,
    output mem_req_ready, mem_resp_valid,
    output mem_resp_rdata,
    input  cpu_req_ready, cpu_resp_valid,
    input  cpu_resp_rdata, flush_done,
    input  mem_req_valid, mem_req_we,
    input  mem_req_addr, mem_req_wdata
  );

  modport slave (
    input  cpu_req_valid, cpu_req_we,
    input  cpu_req_addr, cpu_req_wdata,
    input  cpu_req_be, flush_req,
    input  mem_req_ready, mem_resp_valid,
    input  mem_resp_rdata,
    output cpu_req_ready, cpu_resp_valid,
    output cpu_resp_rdata, flush_done,
    output mem_req_valid, mem_req_we,
    output mem_req_addr, mem_req_wdata
  );
endinterface

// File: rtl/assoc_wb_cache_ctrl.sv
// Set-associative write-back/write-allocate cache
// controller, one word per line, true-LRU, full flush.
module assoc_wb_cache_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SETS   = 4,
  parameter int WAYS   = 2
) (
  input logic                  clk,
  input logic                  rst,
  assoc_wb_cache_ctrl_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int AW    = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, RESP, WB,
    FILL_REQ, FILL_WAIT, FL_SCAN, FL_WB
  } state_t;

  state_t st_q, st_d;

  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS];
  logic              valid_q [SETS][WAYS];
  logic              dirty_q [SETS][WAYS];
  logic [AW-1:0]     age_q   [SETS][WAYS];

  logic              req_we;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic [AW-1:0]     victim_q;
  logic [DATA_W-1:0] resp_q;
  logic [IDX_W-1:0]  fl_set;
  logic [AW-1:0]     fl_way;

  logic          hit;
  logic [AW-1:0] hit_way;
  logic [AW-1:0] victim;
  logic          found;
  logic          accept;
  logic          fill;
  logic          fl_last;
  logic          fl_step;
  logic          lru_en;
  logic [AW-1:0] lru_way;
  logic [AW-1:0] lru_old;

  logic              ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              done;
  logic              m_valid;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;

  logic unused_ok;
  assign unused_ok = ^bus.cpu_req_addr;

  function automatic logic [DATA_W-1:0] merge(
    input logic [DATA_W-1:0] o,
    input logic [DATA_W-1:0] n,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] r;
    r = o;
    for (int b = 0; b < BE_W; b++)
      if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] line_addr(
    input logic [TAG_W-1:0] t,
    input logic [IDX_W-1:0] i
  );
    return ADDR_W'({t, i}) << OFF_W;
  endfunction

  assign accept  = bus.cpu_req_valid && ready;
  assign fill    = (st_q == FILL_WAIT) &&
                   bus.mem_resp_valid;
  assign fl_last = (fl_set == IDX_W'(SETS - 1)) &&
                   (fl_way == AW'(WAYS - 1));
  assign fl_step = (st_q == FL_SCAN) &&
                   !dirty_q[fl_set][fl_way] &&
                   !fl_last;
  assign lru_en  = ((st_q == LOOKUP) && hit) || fill;
  assign lru_way = (st_q == LOOKUP) ? hit_way
                                    : victim_q;
  assign lru_old = age_q[req_idx][lru_way];

  // Tag compare across the ways of the requested set
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] &&
          tag_q[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = AW'(w);
      end
    end
  end

  // Victim: lowest invalid way, else the oldest way
  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (age_q[req_idx][w] == AW'(WAYS - 1))
        victim = AW'(w);
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_q[req_idx][w]) begin
        found  = 1'b1;
        victim = AW'(w);
      end
    end
  end

  // Next state and all port outputs
  always_comb begin
    st_d       = st_q;
    ready      = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    done       = 1'b0;
    m_valid    = 1'b0;
    m_we       = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    unique case (st_q)
      IDLE: begin
        ready = rst && !bus.flush_req;
        if (bus.flush_req)
          st_d = FL_SCAN;
        else if (bus.cpu_req_valid)
          st_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit)
          st_d = RESP;
        else if (valid_q[req_idx][victim] &&
                 dirty_q[req_idx][victim])
          st_d = WB;
        else
          st_d = FILL_REQ;
      end
      WB: begin
        m_valid = 1'b1;
        m_we    = 1'b1;
        m_addr  = line_addr(
          tag_q[req_idx][victim_q], req_idx);
        m_wdata = data_q[req_idx][victim_q];
        if (bus.mem_req_ready) st_d = FILL_REQ;
      end
      FILL_REQ: begin
        m_valid = 1'b1;
        m_addr  = line_addr(req_tag, req_idx);
        if (bus.mem_req_ready) st_d = FILL_WAIT;
      end
      FILL_WAIT: begin
        if (bus.mem_resp_valid) st_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = resp_q;
        st_d       = IDLE;
      end
      FL_SCAN: begin
        if (dirty_q[fl_set][fl_way]) begin
          st_d = FL_WB;
        end else if (fl_last) begin
          done = 1'b1;
          st_d = IDLE;
        end
      end
      FL_WB: begin
        m_valid = 1'b1;
        m_we    = 1'b1;
        m_addr  = line_addr(
          tag_q[fl_set][fl_way], fl_set);
        m_wdata = data_q[fl_set][fl_way];
        if (bus.mem_req_ready) st_d = FL_SCAN;
      end
    endcase
  end

  assign bus.cpu_req_ready  = ready;
  assign bus.cpu_resp_valid = resp_valid;
  assign bus.cpu_resp_rdata = resp_rdata;
  assign bus.flush_done     = done;
  assign bus.mem_req_valid  = m_valid;
  assign bus.mem_req_we     = m_we;
  assign bus.mem_req_addr   = m_addr;
  assign bus.mem_req_wdata  = m_wdata;

  // State, captured request, response and flush walk
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q      <= IDLE;
      req_we    <= 1'b0;
      req_tag   <= '0;
      req_idx   <= '0;
      req_wdata <= '0;
      req_be    <= '0;
      victim_q  <= '0;
      resp_q    <= '0;
      fl_set    <= '0;
      fl_way    <= '0;
    end else begin
      st_q <= st_d;
      if (accept) begin
        req_we    <= bus.cpu_req_we;
        req_tag   <= bus.cpu_req_addr[ADDR_W-1 -: TAG_W];
        req_idx   <= bus.cpu_req_addr[OFF_W +: IDX_W];
        req_wdata <= bus.cpu_req_wdata;
        req_be    <= bus.cpu_req_be;
      end
      if (st_q == LOOKUP) begin
        victim_q <= victim;
        resp_q   <= (hit && !req_we)
                    ? data_q[req_idx][hit_way] : '0;
      end
      if (fill)
        resp_q <= req_we ? '0 : bus.mem_resp_rdata;
      if (st_q == IDLE) begin
        fl_set <= '0;
        fl_way <= '0;
      end else if (fl_step) begin
        if (fl_way == AW'(WAYS - 1)) begin
          fl_way <= '0;
          fl_set <= fl_set + 1'b1;
        end else begin
          fl_way <= fl_way + 1'b1;
        end
      end
    end
  end

  // Valid, dirty and LRU age state
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w]   <= AW'(w);
        end
      end
    end else begin
      if ((st_q == LOOKUP) && hit && req_we)
        dirty_q[req_idx][hit_way] <= 1'b1;
      if (fill) begin
        valid_q[req_idx][victim_q] <= 1'b1;
        dirty_q[req_idx][victim_q] <= req_we;
      end
      if ((st_q == FL_WB) && bus.mem_req_ready)
        dirty_q[fl_set][fl_way] <= 1'b0;
      if (lru_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (AW'(w) == lru_way)
            age_q[req_idx][w] <= '0;
          else if (age_q[req_idx][w] < lru_old)
            age_q[req_idx][w] <=
              age_q[req_idx][w] + 1'b1;
        end
      end
    end
  end

  // Tag and data arrays, written only outside reset
  always_ff @(posedge clk) begin
    if (rst) begin
      if ((st_q == LOOKUP) && hit && req_we)
        data_q[req_idx][hit_way] <= merge(
          data_q[req_idx][hit_way],
          req_wdata, req_be);
      if (fill) begin
        tag_q[req_idx][victim_q]  <= req_tag;
        data_q[req_idx][victim_q] <= req_we
          ? merge(bus.mem_resp_rdata,
                  req_wdata, req_be)
          : bus.mem_resp_rdata;
      end
    end
  end
endmodule
